queue_call_scheduler: RTL and testbench

- Sequences the bank queue: turns front/back photo-beam interruptions into a synchronous customer count (Pcount).
- Shares the queue's head customer between T teller counters with a round-robin call arbiter.
- Sits between the beam sensors / teller "next" buttons and the display/indicator logic; replaces the edge-triggered counter with a single-clock controller.

---
 rtl/queue_call_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_queue_call_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/queue_call_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : queue_call_scheduler                                          |
// | Function : Bank-queue sequencer. Converts entry/exit photo-beam          |
// |            interruptions into a saturating customer count (Pcount) and   |
// |            hands the head customer to one of T tellers through a         |
// |            round-robin call arbiter with a call timeout.                 |
// | Options  : QUEUE_CALL_WAIT_TIME_EN adds SVC_MIN and the Wtime output     |
// |            (estimated wait = Pcount * SVC_MIN).                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module queue_call_scheduler #(
   parameter int n       = 3,
   parameter int T       = 3,
   parameter int TIMEOUT = 1000
`ifdef QUEUE_CALL_WAIT_TIME_EN
   ,
   parameter int SVC_MIN = 3
`endif
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic         back_beam,
   input  logic         front_beam,
   input  logic [T-1:0] teller_req,
   output logic [T-1:0] teller_grant,
   output logic         call_active,
   output logic         timeout_pulse,
   output logic [n-1:0] Pcount,
   output logic         empty_flag,
   output logic         full_flag
`ifdef QUEUE_CALL_WAIT_TIME_EN
   ,
   output logic [n+3:0] Wtime
`endif
);

   // Index width for teller numbers and timer width
   localparam int c_IW = (T > 1) ? $clog2(T) : 1;
   localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [n-1:0]    c_FULL     = '1;
   localparam logic [T-1:0]    c_ONE      = T'(1);
   localparam logic [c_IW-1:0] c_LAST_T   = c_IW'(T - 1);
   localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
   localparam logic [c_IW:0]   c_T_EXT    = (c_IW + 1)'(T);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_CALL = 1'b1
   } state_t;

   // Beam synchronisers and previous-value registers (idle level is 1)
   logic r_back_s1, r_back_s2, r_back_prev;
   logic r_front_s1, r_front_s2, r_front_prev;
   logic w_back_ev, w_front_ev;

   // Customer count
   logic [n-1:0] r_count;

   // Call FSM state
   state_t          r_state, w_state_nx;
   logic [T-1:0]    r_grant, w_grant_nx;
   logic [c_IW-1:0] r_idx, w_idx_nx;
   logic [c_TW-1:0] r_timer, w_timer_nx;
   logic [c_IW-1:0] r_last, w_last_nx;
   logic            r_tmo, w_tmo_nx;

   // Round-robin search
   logic [c_IW-1:0] w_start;
   logic [c_IW:0]   w_sum;
   logic [c_IW-1:0] w_pick;
   logic            w_found;

   // Two-flop synchronisers followed by a previous-value stage for edge detect
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_back_s1    <= 1'b1;
         r_back_s2    <= 1'b1;
         r_back_prev  <= 1'b1;
         r_front_s1   <= 1'b1;
         r_front_s2   <= 1'b1;
         r_front_prev <= 1'b1;
      end else begin
         r_back_s1    <= back_beam;
         r_back_s2    <= r_back_s1;
         r_back_prev  <= r_back_s2;
         r_front_s1   <= front_beam;
         r_front_s2   <= r_front_s1;
         r_front_prev <= r_front_s2;
      end
   end

   // A beam event is a synchronised falling edge; a held-low beam fires once
   assign w_back_ev  = r_back_prev  & ~r_back_s2;
   assign w_front_ev = r_front_prev & ~r_front_s2;

   // Saturating up/down count; coincident entry and exit cancel out
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_count <= '0;
      end else if (w_back_ev && !w_front_ev) begin
         if (r_count != c_FULL) begin
            r_count <= r_count + 1'b1;
         end
      end else if (w_front_ev && !w_back_ev) begin
         if (r_count != '0) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // First teller to try is the one after the most recently served one
   always_comb begin
      w_start = (r_last == c_LAST_T) ? '0 : r_last + 1'b1;
   end

   // Scan from the farthest offset back to the nearest so the nearest wins
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      for (int k = T - 1; k >= 0; k--) begin
         w_sum = {1'b0, w_start} + (c_IW + 1)'(k);
         if (w_sum >= c_T_EXT) begin
            w_sum = w_sum - c_T_EXT;
         end
         if (teller_req[w_sum[c_IW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_sum[c_IW-1:0];
         end
      end
   end

   // Call FSM state registers
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_timer <= '0;
         r_last  <= c_LAST_T;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_grant <= w_grant_nx;
         r_idx   <= w_idx_nx;
         r_timer <= w_timer_nx;
         r_last  <= w_last_nx;
         r_tmo   <= w_tmo_nx;
      end
   end

   // Call FSM next state: exit on customer arrival, teller withdrawal or timeout
   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_idx_nx   = r_idx;
      w_timer_nx = r_timer;
      w_last_nx  = r_last;
      w_tmo_nx   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((r_count != '0) && w_found) begin
               w_state_nx = S_CALL;
               w_grant_nx = c_ONE << w_pick;
               w_idx_nx   = w_pick;
               w_timer_nx = '0;
            end
         end
         S_CALL: begin
            if (w_front_ev) begin
               // Customer walked to the counter: this teller was served
               w_state_nx = S_IDLE;
               w_grant_nx = '0;
               w_last_nx  = r_idx;
            end else if (!teller_req[r_idx]) begin
               // Teller withdrew: rotation pointer stays put
               w_state_nx = S_IDLE;
               w_grant_nx = '0;
            end else if (r_timer == c_TMO_LAST) begin
               // Nobody came: abandon and rotate past this teller
               w_state_nx = S_IDLE;
               w_grant_nx = '0;
               w_last_nx  = r_idx;
               w_tmo_nx   = 1'b1;
            end else begin
               w_timer_nx = r_timer + 1'b1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_grant_nx = '0;
         end
      endcase
   end

`ifdef QUEUE_CALL_WAIT_TIME_EN
   logic [n+3:0] r_wtime;

   // Estimated wait follows the count by one cycle
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_wtime <= '0;
      end else begin
         r_wtime <= {4'b0000, r_count} * (n + 4)'(SVC_MIN);
      end
   end

   assign Wtime = r_wtime;
`endif

   assign teller_grant  = r_grant;
   assign call_active   = |r_grant;
   assign timeout_pulse = r_tmo;
   assign Pcount        = r_count;
   assign empty_flag    = (r_count == '0);
   assign full_flag     = (r_count == c_FULL);

endmodule
`default_nettype wire

// File: tb/tb_queue_call_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_queue_call_scheduler                                       |
// | Function : Directed self-checking bench for queue_call_scheduler         |
// |            (n=3, T=3, TIMEOUT=20).                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_queue_call_scheduler;

   logic       clk = 1'b0;
   logic       Reset;
   logic       back_beam;
   logic       front_beam;
   logic [2:0] teller_req;
   logic [2:0] teller_grant;
   logic       call_active;
   logic       timeout_pulse;
   logic [2:0] Pcount;
   logic       empty_flag;
   logic       full_flag;
`ifdef QUEUE_CALL_WAIT_TIME_EN
   logic [6:0] Wtime;
`endif

   int n_cmp = 0;
   int n_err = 0;

   queue_call_scheduler #(
      .n       (3),
      .T       (3),
      .TIMEOUT (20)
   ) dut (
      .clk           (clk),
      .Reset         (Reset),
      .back_beam     (back_beam),
      .front_beam    (front_beam),
      .teller_req    (teller_req),
      .teller_grant  (teller_grant),
      .call_active   (call_active),
      .timeout_pulse (timeout_pulse),
      .Pcount        (Pcount),
      .empty_flag    (empty_flag),
      .full_flag     (full_flag)
`ifdef QUEUE_CALL_WAIT_TIME_EN
      ,
      .Wtime         (Wtime)
`endif
   );

   always #5 clk = ~clk;

   // One beam pulse: 5 clk low, 5 clk high (starts and ends at a falling clk)
   task automatic beam_pulse(input bit front);
      if (front) front_beam = 1'b0; else back_beam = 1'b0;
      repeat (5) @(negedge clk);
      if (front) front_beam = 1'b1; else back_beam = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   // Front event during a call: grant held, then cleared with count change, then next grant
   task automatic front_step(input logic [2:0] g_before, input logic [2:0] c_after,
                             input logic [2:0] g_after);
      front_beam = 1'b0;
      @(negedge clk); @(negedge clk);
      n_cmp++; if (teller_grant !== g_before) begin n_err++; $display("FAIL front_hold: grant=%b expected %b", teller_grant, g_before); end
      @(negedge clk);
      front_beam = 1'b1;
      n_cmp++; if (teller_grant !== 3'b000) begin n_err++; $display("FAIL front_clear: grant=%b expected 000", teller_grant); end
      n_cmp++; if (Pcount !== c_after) begin n_err++; $display("FAIL front_count: Pcount=%0d expected %0d", Pcount, c_after); end
      @(negedge clk);
      n_cmp++; if (teller_grant !== g_after) begin n_err++; $display("FAIL front_next: grant=%b expected %b", teller_grant, g_after); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      Reset = 1'b1; back_beam = 1'b1; front_beam = 1'b1; teller_req = 3'b000;
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (Pcount !== 3'd0) begin n_err++; $display("FAIL rst_count: Pcount=%0d expected 0", Pcount); end
      n_cmp++; if (empty_flag !== 1'b1 || full_flag !== 1'b0) begin n_err++; $display("FAIL rst_flags: empty=%b full=%b expected 1 0", empty_flag, full_flag); end
      n_cmp++; if (teller_grant !== 3'b000 || call_active !== 1'b0 || timeout_pulse !== 1'b0) begin n_err++; $display("FAIL rst_call: grant=%b active=%b tmo=%b expected 000 0 0", teller_grant, call_active, timeout_pulse); end
   endtask

   task automatic test_count_up();
      for (int i = 0; i < 3; i++) begin
         back_beam = 1'b0;
         @(negedge clk); @(negedge clk);
         n_cmp++; if (Pcount !== 3'(i)) begin n_err++; $display("FAIL inc_early: Pcount=%0d expected %0d", Pcount, i); end
         @(negedge clk);
         n_cmp++; if (Pcount !== 3'(i + 1)) begin n_err++; $display("FAIL inc_3clk: Pcount=%0d expected %0d", Pcount, i + 1); end
         @(negedge clk); @(negedge clk);
         n_cmp++; if (Pcount !== 3'(i + 1)) begin n_err++; $display("FAIL inc_once: Pcount=%0d expected %0d", Pcount, i + 1); end
         back_beam = 1'b1;
         repeat (5) @(negedge clk);
      end
      n_cmp++; if (Pcount !== 3'd3 || empty_flag !== 1'b0) begin n_err++; $display("FAIL count3: Pcount=%0d empty=%b expected 3 0", Pcount, empty_flag); end
   endtask

   task automatic test_saturate();
      repeat (4) beam_pulse(1'b0);
      n_cmp++; if (Pcount !== 3'd7 || full_flag !== 1'b1) begin n_err++; $display("FAIL full7: Pcount=%0d full=%b expected 7 1", Pcount, full_flag); end
      repeat (2) beam_pulse(1'b0);
      n_cmp++; if (Pcount !== 3'd7 || full_flag !== 1'b1) begin n_err++; $display("FAIL sat_hi: Pcount=%0d full=%b expected 7 1", Pcount, full_flag); end
      back_beam = 1'b0; front_beam = 1'b0;
      repeat (5) @(negedge clk);
      back_beam = 1'b1; front_beam = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++; if (Pcount !== 3'd7) begin n_err++; $display("FAIL both_same: Pcount=%0d expected 7", Pcount); end
      beam_pulse(1'b1);
      n_cmp++; if (Pcount !== 3'd6 || full_flag !== 1'b0) begin n_err++; $display("FAIL dec6: Pcount=%0d full=%b expected 6 0", Pcount, full_flag); end
      repeat (4) beam_pulse(1'b1);
      n_cmp++; if (Pcount !== 3'd2) begin n_err++; $display("FAIL dec2: Pcount=%0d expected 2", Pcount); end
   endtask

   task automatic test_round_robin();
      teller_req = 3'b111;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b001 || call_active !== 1'b1) begin n_err++; $display("FAIL rr_first: grant=%b active=%b expected 001 1", teller_grant, call_active); end
      front_step(3'b001, 3'd1, 3'b010);
      front_step(3'b010, 3'd0, 3'b000);
      teller_req = 3'b000;
      repeat (2) beam_pulse(1'b0);
      teller_req = 3'b111;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b100) begin n_err++; $display("FAIL rr_third: grant=%b expected 100", teller_grant); end
      front_step(3'b100, 3'd1, 3'b001);
      front_step(3'b001, 3'd0, 3'b000);
      teller_req = 3'b000;
   endtask

   task automatic test_timeout();
      beam_pulse(1'b0);
      teller_req = 3'b111;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b010) begin n_err++; $display("FAIL tmo_grant: grant=%b expected 010", teller_grant); end
      repeat (19) @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b010 || timeout_pulse !== 1'b0) begin n_err++; $display("FAIL tmo_early: grant=%b tmo=%b expected 010 0", teller_grant, timeout_pulse); end
      @(negedge clk);
      n_cmp++; if (timeout_pulse !== 1'b1 || teller_grant !== 3'b000) begin n_err++; $display("FAIL tmo_fire: tmo=%b grant=%b expected 1 000", timeout_pulse, teller_grant); end
      n_cmp++; if (Pcount !== 3'd1) begin n_err++; $display("FAIL tmo_count: Pcount=%0d expected 1", Pcount); end
      @(negedge clk);
      n_cmp++; if (timeout_pulse !== 1'b0 || teller_grant !== 3'b100) begin n_err++; $display("FAIL tmo_after: tmo=%b grant=%b expected 0 100", timeout_pulse, teller_grant); end
   endtask

   task automatic test_abandon();
      teller_req = 3'b000;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b000 || Pcount !== 3'd1) begin n_err++; $display("FAIL ab_t2: grant=%b Pcount=%0d expected 000 1", teller_grant, Pcount); end
      teller_req = 3'b001;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b001) begin n_err++; $display("FAIL ab_g0: grant=%b expected 001", teller_grant); end
      teller_req = 3'b000;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b000 || Pcount !== 3'd1) begin n_err++; $display("FAIL ab_t0: grant=%b Pcount=%0d expected 000 1", teller_grant, Pcount); end
      teller_req = 3'b111;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b100) begin n_err++; $display("FAIL ab_ptr: grant=%b expected 100", teller_grant); end
      teller_req = 3'b000;
      @(negedge clk);
      repeat (2) beam_pulse(1'b1);
      n_cmp++; if (Pcount !== 3'd0 || empty_flag !== 1'b1) begin n_err++; $display("FAIL sat_lo: Pcount=%0d empty=%b expected 0 1", Pcount, empty_flag); end
      teller_req = 3'b111;
      repeat (3) @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b000 || call_active !== 1'b0) begin n_err++; $display("FAIL empty_nocall: grant=%b active=%b expected 000 0", teller_grant, call_active); end
      teller_req = 3'b000;
   endtask

   task automatic test_reset_mid_call();
      repeat (4) beam_pulse(1'b0);
`ifdef QUEUE_CALL_WAIT_TIME_EN
      n_cmp++; if (Wtime !== 7'd12) begin n_err++; $display("FAIL wtime4: Wtime=%0d expected 12", Wtime); end
`endif
      beam_pulse(1'b0);
      n_cmp++; if (Pcount !== 3'd5) begin n_err++; $display("FAIL count5: Pcount=%0d expected 5", Pcount); end
      teller_req = 3'b111;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b100) begin n_err++; $display("FAIL pre_rst_grant: grant=%b expected 100", teller_grant); end
      Reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (Pcount !== 3'd0 || teller_grant !== 3'b000 || empty_flag !== 1'b1) begin n_err++; $display("FAIL mid_rst: Pcount=%0d grant=%b empty=%b expected 0 000 1", Pcount, teller_grant, empty_flag); end
      Reset = 1'b0;
      teller_req = 3'b000;
      beam_pulse(1'b0);
      teller_req = 3'b111;
      @(negedge clk);
      n_cmp++; if (teller_grant !== 3'b001) begin n_err++; $display("FAIL rst_ptr: grant=%b expected 001", teller_grant); end
      teller_req = 3'b000;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_saturate();
      test_round_robin();
      test_timeout();
      test_abandon();
      test_reset_mid_call();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1);
   end

endmodule
`default_nettype wire
